// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle combinational ALU plus an iterative multiply/divide
// unit with HI/LO registers and a start/busy/done handshake.
//
// Optional feature macro: ALU_SIGNED_MD_EN
//   defined     -> md_op[1] selects signed MULT/DIV, FIX state present
//   not defined -> md_op[1] ignored, every mul/div is unsigned
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for md_start
// RUN   | one multiply/divide bit per cycle; divisor==0 exits after one
// FIX   | sign correction of the magnitude result (signed build only)
// DONE  | hi/lo hold the new result, md_done pulses, return to IDLE

module alu_muldiv #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   srcA,
    input  logic [WIDTH-1:0]   srcB,
    input  logic [3:0]         aluControl,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   aluResult,
    output logic               zero,
    input  logic               md_start,
    input  logic [1:0]         md_op,
    output logic               md_busy,
    output logic               md_done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
`ifdef ALU_SIGNED_MD_EN
    localparam logic [1:0] S_FIX  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    // Combinational ALU, independent of the mul/div unit
    always_comb begin
        aluResult = '0;
        case (aluControl)
            4'b0000: aluResult = srcA & srcB;
            4'b0001: aluResult = srcA | srcB;
            4'b0010: aluResult = srcA + srcB;
            4'b0110: aluResult = srcA - srcB;
            4'b0111: aluResult = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            4'b0011: aluResult = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            4'b1010: aluResult = srcB << shamt;
            4'b1011: aluResult = srcB >> shamt;
            4'b1001: aluResult = $signed(srcB) >>> shamt;
            4'b1100: aluResult = ~(srcA | srcB);
            4'b1101: aluResult = srcA ^ srcB;
            4'b1110: aluResult = {srcB[HALF-1:0], {HALF{1'b0}}};
            default: aluResult = '0;
        endcase
    end

    assign zero = (aluResult == '0);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               is_div_q, is_div_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               dbz_flag_q, dbz_flag_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Operand magnitudes; the unsigned build uses the operands as-is
    logic [WIDTH-1:0] mag_a, mag_b;
`ifdef ALU_SIGNED_MD_EN
    logic sgn_q, sgn_d;
    logic neg_lo_q, neg_lo_d;
    logic neg_hi_q, neg_hi_d;
    logic neg_a, neg_b;

    always_comb begin
        neg_a = md_op[1] & srcA[WIDTH-1];
        neg_b = md_op[1] & srcB[WIDTH-1];
        mag_a = neg_a ? -srcA : srcA;
        mag_b = neg_b ? -srcB : srcB;
    end
`else
    logic unused_md_op_sign;
    assign unused_md_op_sign = md_op[1];
    assign mag_a = srcA;
    assign mag_b = srcB;
`endif

    // One iteration of shift-add multiply and restoring divide
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               q_bit;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] iter_next;

    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, p_q[WIDTH-1:1]};
        rem_sh    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        rem_diff  = rem_sh - {1'b0, a_q};
        q_bit     = ~rem_diff[WIDTH];
        div_next  = {(q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), p_q[WIDTH-2:0], q_bit};
        iter_next = is_div_q ? div_next : mul_next;
    end

    // Mul/div sequencer: operand latch, iteration, result write-back
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        p_d        = p_q;
        is_div_d   = is_div_q;
        dbz_pend_d = dbz_pend_q;
        dbz_flag_d = dbz_flag_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
`ifdef ALU_SIGNED_MD_EN
        sgn_d      = sgn_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    state_d    = S_RUN;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    is_div_d   = md_op[0];
                    dbz_flag_d = 1'b0;
                    dbz_pend_d = md_op[0] && (srcB == '0);
                    if (md_op[0]) begin
                        a_d = mag_b;
                        // A zero divisor reports the raw dividend in hi
                        p_d = {{WIDTH{1'b0}}, (srcB == '0) ? srcA : mag_a};
                    end else begin
                        a_d = mag_a;
                        p_d = {{WIDTH{1'b0}}, mag_b};
                    end
`ifdef ALU_SIGNED_MD_EN
                    sgn_d    = md_op[1];
                    neg_lo_d = neg_a ^ neg_b;
                    neg_hi_d = neg_a;
`endif
                end
            end
            S_RUN: begin
                if (dbz_pend_q) begin
                    hi_d       = p_q[WIDTH-1:0];
                    lo_d       = '1;
                    dbz_flag_d = 1'b1;
                    dbz_pend_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    p_d   = iter_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
`ifdef ALU_SIGNED_MD_EN
                        if (sgn_q) begin
                            state_d = S_FIX;
                        end else begin
                            {hi_d, lo_d} = iter_next;
                            state_d      = S_DONE;
                        end
`else
                        {hi_d, lo_d} = iter_next;
                        state_d      = S_DONE;
`endif
                    end
                end
            end
`ifdef ALU_SIGNED_MD_EN
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -p_q : p_q;
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            p_q        <= '0;
            is_div_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_flag_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            p_q        <= p_d;
            is_div_q   <= is_div_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_flag_q <= dbz_flag_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

`ifdef ALU_SIGNED_MD_EN
    // Sign bookkeeping for the FIX step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sgn_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            sgn_q    <= sgn_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end
`endif

    assign md_busy     = (state_q != S_IDLE);
    assign md_done     = (state_q == S_DONE);
    assign div_by_zero = dbz_flag_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv (WIDTH=32): comb vector table, random comb ops,
// directed mul/div corner sequences and random mul/div against a 64-bit
// arithmetic reference. Signed cases follow ALU_SIGNED_MD_EN.

module tb_alu_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  srcA, srcB;
    logic [3:0]    aluControl;
    logic [4:0]    shamt;
    logic [W-1:0]  aluResult;
    logic          zero;
    logic          md_start;
    logic [1:0]    md_op;
    logic          md_busy, md_done, div_by_zero;
    logic [W-1:0]  hi, lo;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB),
        .aluControl(aluControl), .shamt(shamt), .aluResult(aluResult), .zero(zero),
        .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic [W-1:0] exp;
    } comb_vec_t;

    comb_vec_t cv[14];

    function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [4:0] sh);
        longint sa, sb;
        logic [63:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b1010: return b << sh;
            4'b1011: return b >> sh;
            4'b1001: begin
                wide = 64'(sb / (longint'(1) << sh));
                if (sb < 0 && (sb % (longint'(1) << sh)) != 0) wide = wide - 64'd1;
                return wide[31:0];
            end
            4'b1100: return ~(a | b);
            4'b1101: return a ^ b;
            4'b1110: return {b[15:0], 16'h0000};
            default: return '0;
        endcase
    endfunction

    function automatic void md_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] eh, output logic [W-1:0] el,
                                     output logic edbz, output int lat);
        logic        sgn;
        longint      sa, sb, q, r;
        logic [63:0] p;
`ifdef ALU_SIGNED_MD_EN
        sgn = op[1];
`else
        sgn = 1'b0;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        edbz = 1'b0;
        lat  = sgn ? 34 : 33;
        if (op[0] && b == 0) begin
            eh = a; el = '1; edbz = 1'b1; lat = 2;
        end else if (!op[0]) begin
            if (sgn) p = 64'(sa * sb);
            else     p = {32'h0, a} * {32'h0, b};
            eh = p[63:32]; el = p[31:0];
        end else begin
            if (sgn) begin
                q = sa / sb; r = sa % sb;
                p = 64'(q); el = p[31:0];
                p = 64'(r); eh = p[31:0];
            end else begin
                el = a / b; eh = a % b;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        logic         edbz, busy_ok;
        int           lat, cyc;
        md_model(op, a, b, eh, el, edbz, lat);
        srcA = a; srcB = b; md_op = op; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!md_done && cyc < 100) begin
            if (!md_busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(lat));
        check({name, " busy"}, {63'd0, busy_ok & md_busy}, 64'd1);
        check({name, " hi"}, {32'd0, hi}, {32'd0, eh});
        check({name, " lo"}, {32'd0, lo}, {32'd0, el});
        check({name, " dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
        tick();
        check({name, " post done/busy"}, {62'd0, md_done, md_busy}, 64'd0);
        check({name, " hold"}, {hi, lo}, {eh, el});
    endtask

    logic [3:0] op_list[13] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011,
                                4'b1010, 4'b1011, 4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b0100};

    initial begin
        int          ndone, cyc_done;
        logic [W-1:0] hd, ld;
        logic [1:0]  rop;
        logic [W-1:0] ra, rb;

        reset = 1'b1;
        srcA = '0; srcB = '0; aluControl = '0; shamt = '0; md_start = 1'b0; md_op = '0;

        cv[0]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000};
        cv[1]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0};
        cv[2]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000002, 5'd0, 32'h00000001};
        cv[3]  = '{4'b0110, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000};
        cv[4]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001};
        cv[5]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000};
        cv[6]  = '{4'b1010, 32'h00000000, 32'h0000000F, 5'd4, 32'h000000F0};
        cv[7]  = '{4'b1011, 32'h00000000, 32'h80000000, 5'd4, 32'h08000000};
        cv[8]  = '{4'b1001, 32'h00000000, 32'h80000000, 5'd4, 32'hF8000000};
        cv[9]  = '{4'b1100, 32'h00000000, 32'hFFFF0000, 5'd0, 32'h0000FFFF};
        cv[10] = '{4'b1101, 32'hAAAA5555, 32'hFFFF0000, 5'd0, 32'h55555555};
        cv[11] = '{4'b1110, 32'hDEADBEEF, 32'h1234ABCD, 5'd0, 32'hABCD0000};
        cv[12] = '{4'b0100, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h00000000};
        cv[13] = '{4'b0110, 32'h00000003, 32'h00000005, 5'd0, 32'hFFFFFFFE};

        #12;
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset flags", {61'd0, md_busy, md_done, div_by_zero}, 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            aluControl = cv[i].ctrl; srcA = cv[i].a; srcB = cv[i].b; shamt = cv[i].sh;
            #1;
            check($sformatf("comb vec %0d", i), {32'd0, aluResult}, {32'd0, cv[i].exp});
            check($sformatf("comb zero %0d", i), {63'd0, zero}, {63'd0, (cv[i].exp == 0)});
        end

        for (int i = 0; i < 40; i++) begin
            aluControl = op_list[$urandom_range(0, 12)];
            srcA = $urandom; srcB = (i % 5 == 0) ? srcA : $urandom; shamt = 5'($urandom);
            #1;
            check($sformatf("comb rand op%0h", aluControl), {32'd0, aluResult},
                  {32'd0, ref_alu(aluControl, srcA, srcB, shamt)});
        end
        tick();

        run_md("multu max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Reset during cycle 5 of a MULTU
        srcA = 32'd3; srcB = 32'd4; md_op = 2'b00; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        check("midrun reset hi/lo", {hi, lo}, 64'd0);
        check("midrun reset busy/done", {62'd0, md_busy, md_done}, 64'd0);
        #2 reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done) ndone++;
        end
        check("midrun no done pulse", 64'(ndone), 64'd0);
        check("midrun stays cleared", {hi, lo}, 64'd0);

        run_md("divu 100/7", 2'b01, 32'd100, 32'd7);
        run_md("divu 5/0", 2'b01, 32'd5, 32'd0);
        check("dbz sticky idle", {63'd0, div_by_zero}, 64'd1);
        run_md("divu after dbz", 2'b01, 32'd9, 32'd3);

`ifdef ALU_SIGNED_MD_EN
        run_md("div -7/2", 2'b11, -32'sd7, 32'd2);
        run_md("mult -3*5", 2'b10, -32'sd3, 32'd5);
        run_md("div min/-1", 2'b11, 32'h80000000, 32'hFFFFFFFF);
        run_md("div 7/-2", 2'b11, 32'd7, -32'sd2);
        run_md("div -5/0", 2'b11, -32'sd5, 32'd0);
`else
        run_md("op11 unsigned div", 2'b11, -32'sd7, 32'd2);
        run_md("op10 unsigned mul", 2'b10, -32'sd3, 32'd5);
`endif

        // md_start pulses during busy are ignored; comb path used meanwhile
        srcA = 32'h00012345; srcB = 32'h00001000; md_op = 2'b00; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        ndone = 0; cyc_done = 0; hd = '0; ld = '0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (md_done) begin
                ndone++; cyc_done = cyc; hd = hi; ld = lo;
            end
            if (cyc == 3 || cyc == 10) begin
                srcA = 32'h7; srcB = 32'h9; md_op = 2'b01; md_start = 1'b1;
            end else begin
                md_start = 1'b0;
                aluControl = op_list[$urandom_range(0, 12)];
                srcA = $urandom; srcB = $urandom; shamt = 5'($urandom);
            end
            #1;
            if (cyc % 8 == 1)
                check("comb while busy", {32'd0, aluResult}, {32'd0, ref_alu(aluControl, srcA, srcB, shamt)});
            @(posedge clk);
            #1;
        end
        md_start = 1'b0;
        check("ignored start done count", 64'(ndone), 64'd1);
        check("ignored start latency", 64'(cyc_done), 64'd33);
        check("ignored start result", {hd, ld}, 64'h0000000012345000);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_md($sformatf("rand md%0d op%0d", i, rop), rop, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
